// File: rtl/lfm_freq_meter_if.sv
// lfm_freq_meter_if: sample/frame inputs (din, din_valid, frame_start, frame_end, f_clk) and measurement outputs (period_out, freq_out, freq_valid, cycle_count, busy, frame_done, overrun, overflow)
interface lfm_freq_meter_if #(
  parameter int IN_WIDTH = 16,
  parameter int CNT_WIDTH = 32
);
  logic [IN_WIDTH-1:0] din;
  logic din_valid;
  logic frame_start;
  logic frame_end;
  logic [31:0] f_clk;
  logic [CNT_WIDTH-1:0] period_out;
  logic [CNT_WIDTH-1:0] freq_out;
  logic freq_valid;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic busy;
  logic frame_done;
  logic overrun;
  logic overflow;
  modport master (
    output din, din_valid, frame_start, frame_end, f_clk,
    input period_out, freq_out, freq_valid, cycle_count, busy, frame_done, overrun, overflow
  );
  modport slave (
    input din, din_valid, frame_start, frame_end, f_clk,
    output period_out, freq_out, freq_valid, cycle_count, busy, frame_done, overrun, overflow
  );
endinterface

// File: rtl/lfm_freq_meter.sv
// lfm_freq_meter: hysteresis zero-crossing period counter with serial restoring divider giving f_clk/period; ports clk, rst, bus (lfm_freq_meter_if.slave)
module lfm_freq_meter #(
  parameter int IN_WIDTH = 16,
  parameter int HYST = 256,
  parameter int CNT_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  lfm_freq_meter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, DONE} state_t;
  localparam int IW = $clog2(CNT_WIDTH + 1);
  localparam longint MID = longint'(1) << (IN_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;
  state_t state_q, state_d;
  logic act, acc, hi, lo, rise, start, fin, step;
  logic lvl_q, lvl_d, ovr_q, ovr_d, ovf_q, ovf_d, dbusy_q, dbusy_d, fv_q, fv_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cc_q, cc_d, fclk_q, fclk_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d, per_q, per_d, frq_q, frq_d;
  logic [IW-1:0] it_q, it_d;
  logic [CNT_WIDTH:0] sh, df;
  always_comb begin
    act = state_q == ARMED || state_q == MEASURE;
    acc = act && bus.din_valid && !bus.frame_start;
    hi = longint'(bus.din) >= MID + HYST;
    lo = longint'(bus.din) <= MID - HYST;
    rise = acc && !lvl_q && hi;
    start = rise && state_q == MEASURE && !dbusy_q;
    fin = dbusy_q && it_q == IW'(CNT_WIDTH);
    step = dbusy_q && !fin;
    sh = {rem_q, quo_q[CNT_WIDTH-1]};
    df = sh - {1'b0, dsr_q};
    state_d = bus.frame_start ? ARMED :
              (bus.frame_end && act) ? DONE :
              state_q == DONE ? IDLE :
              (rise && state_q == ARMED) ? MEASURE : state_q;
  end
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  always_comb begin
    lvl_d = bus.frame_start ? 1'b0 : !acc ? lvl_q : hi ? 1'b1 : lo ? 1'b0 : lvl_q;
    cnt_d = bus.frame_start ? '0 : !acc ? cnt_q : rise ? CNT_WIDTH'(1) :
            cnt_q == CMAX ? CMAX : cnt_q + 1'b1;
    ovf_d = !bus.frame_start && (ovf_q || (acc && !rise && cnt_q == CMAX));
    cc_d = bus.frame_start ? '0 : rise ? cc_q + 1'b1 : cc_q;
    // a crossing that finds the divider occupied is counted but not measured
    ovr_d = !bus.frame_start && (ovr_q || (rise && state_q == MEASURE && dbusy_q));
    fclk_d = bus.frame_start ? CNT_WIDTH'(bus.f_clk) : fclk_q;
    // the counter already includes the previous crossing sample, so it is the period
    dbusy_d = start || step;
    it_d = start ? '0 : step ? it_q + 1'b1 : it_q;
    rem_d = start ? '0 : step ? (df[CNT_WIDTH] ? sh[CNT_WIDTH-1:0] : df[CNT_WIDTH-1:0]) : rem_q;
    quo_d = start ? fclk_q : step ? {quo_q[CNT_WIDTH-2:0], !df[CNT_WIDTH]} : quo_q;
    dsr_d = start ? cnt_q : dsr_q;
    per_d = fin ? dsr_q : per_q;
    frq_d = fin ? quo_q : frq_q;
    fv_d = fin;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      cc_q <= '0;
      ovr_q <= 1'b0;
      fclk_q <= '0;
      dbusy_q <= 1'b0;
      it_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      per_q <= '0;
      frq_q <= '0;
      fv_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      cc_q <= cc_d;
      ovr_q <= ovr_d;
      fclk_q <= fclk_d;
      dbusy_q <= dbusy_d;
      it_q <= it_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dsr_q <= dsr_d;
      per_q <= per_d;
      frq_q <= frq_d;
      fv_q <= fv_d;
    end
  end
  assign bus.period_out = per_q;
  assign bus.freq_out = frq_q;
  assign bus.freq_valid = fv_q;
  assign bus.cycle_count = cc_q;
  assign bus.busy = state_q == ARMED || state_q == MEASURE;
  assign bus.frame_done = state_q == DONE;
  assign bus.overrun = ovr_q;
  assign bus.overflow = ovf_q;
endmodule
